// File: rtl/ldr_pkg.sv
// Register map and sequencer state encoding for the
// Levinson-Durbin wrapper master.
package ldr_pkg;

   localparam logic [15:0] LDR_ADDR_RST   = 16'h0000;
   localparam logic [15:0] LDR_ADDR_START = 16'h0001;
   localparam logic [15:0] LDR_ADDR_DONE  = 16'h0002;
   localparam logic [15:0] LDR_ADDR_R0    = 16'h0003;
   localparam logic [15:0] LDR_ADDR_A0    = 16'h000E;
   localparam logic [15:0] LDR_ADDR_CNT   = 16'h0019;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST1,
      S_RST0,
      S_LOAD,
      S_STA1,
      S_STA0,
      S_POLL,
      S_PWAIT,
      S_RD,
      S_RWAIT,
      S_OUT
   } ldr_state_e;

endpackage

// File: rtl/ldr_rd_align.sv
// Delays the read strobe by the slave read latency so the
// FSM knows the cycle in which readdata is valid.
module ldr_rd_align #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic read,
   output logic rd_valid
);

   logic [LAT-1:0] sr;

   generate
      if (LAT == 1) begin : g_one
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) sr <= '0;
            else      sr <= read;
         end
      end else begin : g_many
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) sr <= '0;
            else      sr <= {sr[LAT-2:0], read};
         end
      end
   endgenerate

   assign rd_valid = sr[LAT-1];

endmodule

// File: rtl/ldr_sequencer.sv
// Avalon-MM master running one Levinson-Durbin solve per
// frame: load R0..R[ORDER], start, poll done, read A out.
module ldr_sequencer
   import ldr_pkg::*;
#(
   parameter int ORDER        = 10,
   parameter int READ_LATENCY = 1,
   parameter int POLL_TIMEOUT = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] r_data,
   input  logic        r_valid,
   output logic        r_ready,
   output logic [15:0] a_data,
   output logic [3:0]  a_index,
   output logic        a_last,
   output logic        a_valid,
   input  logic        a_ready,
   output logic [15:0] address,
   output logic        read,
   output logic        write,
   output logic [15:0] writedata,
   input  logic [15:0] readdata,
   output logic        busy,
   output logic        err
);

   localparam int PW = $clog2(POLL_TIMEOUT + 1);
   localparam logic [3:0]    KMAX = 4'(ORDER);
   localparam logic [PW-1:0] PMAX = PW'(POLL_TIMEOUT);

   generate
      if (ORDER < 1 || ORDER > 15) begin : g_bad_order
         $error("ldr_sequencer: ORDER must be 1..15");
      end
      if (READ_LATENCY < 1) begin : g_bad_lat
         $error("ldr_sequencer: READ_LATENCY must be >= 1");
      end
      if (POLL_TIMEOUT < 1) begin : g_bad_tmo
         $error("ldr_sequencer: POLL_TIMEOUT must be >= 1");
      end
   endgenerate

   ldr_state_e    state;
   ldr_state_e    nstate;
   logic [3:0]    k;
   logic [PW-1:0] pcnt;
   logic          rd_valid;

   ldr_rd_align #(
      .LAT (READ_LATENCY)
   ) u_align (
      .clk      (clk),
      .rst      (rst),
      .read     (read),
      .rd_valid (rd_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= nstate;
   end

   always_comb begin
      nstate    = state;
      r_ready   = 1'b0;
      write     = 1'b0;
      read      = 1'b0;
      address   = '0;
      writedata = '0;
      unique case (state)
         S_IDLE: begin
            if (r_valid) nstate = S_RST1;
         end
         S_RST1: begin
            write     = 1'b1;
            address   = LDR_ADDR_RST;
            writedata = 16'd1;
            nstate    = S_RST0;
         end
         S_RST0: begin
            write   = 1'b1;
            address = LDR_ADDR_RST;
            nstate  = S_LOAD;
         end
         S_LOAD: begin
            r_ready = 1'b1;
            if (r_valid) begin
               write     = 1'b1;
               address   = LDR_ADDR_R0 + {12'd0, k};
               writedata = r_data;
               if (k == KMAX) nstate = S_STA1;
            end
         end
         S_STA1: begin
            write     = 1'b1;
            address   = LDR_ADDR_START;
            writedata = 16'd1;
            nstate    = S_STA0;
         end
         S_STA0: begin
            write   = 1'b1;
            address = LDR_ADDR_START;
            nstate  = S_POLL;
         end
         S_POLL: begin
            read    = 1'b1;
            address = LDR_ADDR_DONE;
            nstate  = S_PWAIT;
         end
         S_PWAIT: begin
            if (rd_valid) begin
               if (readdata != 16'd0)  nstate = S_RD;
               else if (pcnt == PMAX)  nstate = S_IDLE;
               else                    nstate = S_POLL;
            end
         end
         S_RD: begin
            read    = 1'b1;
            address = LDR_ADDR_A0 + {12'd0, k};
            nstate  = S_RWAIT;
         end
         S_RWAIT: begin
            if (rd_valid) nstate = S_OUT;
         end
         S_OUT: begin
            if (a_ready) nstate = (k == KMAX) ? S_IDLE : S_RD;
         end
         default: nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k       <= '0;
         pcnt    <= '0;
         err     <= 1'b0;
         a_data  <= '0;
         a_index <= '0;
         a_last  <= 1'b0;
         a_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (r_valid) err <= 1'b0;
            S_RST0: k <= '0;
            S_LOAD: if (r_valid && k != KMAX) k <= k + 4'd1;
            S_STA0: pcnt <= '0;
            S_PWAIT: begin
               if (rd_valid) begin
                  if (readdata != 16'd0) k <= '0;
                  else if (pcnt == PMAX) err <= 1'b1;
                  else                   pcnt <= pcnt + 1'b1;
               end
            end
            S_RWAIT: begin
               if (rd_valid) begin
                  a_data  <= readdata;
                  a_index <= k;
                  a_last  <= (k == KMAX);
                  a_valid <= 1'b1;
               end
            end
            S_OUT: begin
               if (a_ready) begin
                  a_valid <= 1'b0;
                  if (k != KMAX) k <= k + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ldr_sequencer.sv
// Scoreboard bench for ldr_sequencer with a behavioural
// model of the wrapper slave and a stalling consumer.
module tb_ldr_sequencer;

   localparam int PT = 4095;

   typedef logic [15:0] frame_t [11];

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
   } bus_t;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  idx;
      logic        last;
   } out_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] r_data = '0;
   logic        r_valid = 1'b0;
   logic        r_ready;
   logic [15:0] a_data;
   logic [3:0]  a_index;
   logic        a_last;
   logic        a_valid;
   logic        a_ready;
   logic [15:0] address;
   logic        read;
   logic        write;
   logic [15:0] writedata;
   logic [15:0] readdata = '0;
   logic        busy;
   logic        err;

   bus_t bus_q[$];
   out_t out_q[$];

   int checks = 0;
   int errors = 0;
   int fno = 0;
   int starts = 0;
   int dreads = 0;
   int done_after = 40;
   int bp = 0;
   int hold = 0;
   int av_cnt = 0;

   logic        ph = 1'b0;
   logic [15:0] pd = '0;
   logic [3:0]  pi = '0;
   logic        pl = 1'b0;

   always #5 clk = ~clk;

   ldr_sequencer #(
      .ORDER        (10),
      .READ_LATENCY (1),
      .POLL_TIMEOUT (PT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .r_data    (r_data),
      .r_valid   (r_valid),
      .r_ready   (r_ready),
      .a_data    (a_data),
      .a_index   (a_index),
      .a_last    (a_last),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .busy      (busy),
      .err       (err)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // slave model: done after done_after zero polls, A_k = base+k
   always @(posedge clk) begin
      if (rst && write && address == 16'h1 && writedata == 16'h1) begin
         starts++;
         dreads = 0;
      end
      if (rst && read) begin
         if (address == 16'h2) begin
            readdata <= (dreads >= done_after) ? 16'd1 : 16'd0;
            dreads++;
         end else if (address >= 16'hE && address <= 16'h18) begin
            readdata <= 16'(100 + 20 * (starts - 1) + (int'(address) - 14));
         end else begin
            readdata <= 16'h0;
         end
      end
   end

   initial begin
      a_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         hold = a_valid ? hold + 1 : 0;
         a_ready = (hold > bp);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         bus_t e;
         out_t o;
         if (a_valid) av_cnt++;
         if (write && read) check("two_strobes", 1, 0);
         if (write || read) begin
            if (bus_q.size() == 0) begin
               check("bus_unexp",
                     {30'd0, write, read, address, writedata}, 64'd0);
            end else begin
               e = bus_q.pop_front();
               check("bus",
                     {30'd0, write, read, address,
                      write ? writedata : 16'h0},
                     {30'd0, e.wr, !e.wr, e.addr,
                      e.wr ? e.data : 16'h0});
            end
         end
         if (r_ready) check("gap_wr", 64'(write), 64'(r_valid));
         if (a_valid) check("rd_pend", 64'(read), 64'd0);
         if (ph) begin
            check("hold", {43'd0, a_valid, a_data, a_index, a_last},
                  {43'd0, 1'b1, pd, pi, pl});
         end
         if (a_valid && a_ready) begin
            if (out_q.size() == 0) begin
               check("out_unexp", {43'd1, a_data, a_index, a_last}, 64'd0);
            end else begin
               o = out_q.pop_front();
               check("out", {43'd0, a_data, a_index, a_last},
                     {43'd0, o.data, o.idx, o.last});
            end
         end
         ph = a_valid && !a_ready;
         pd = a_data;
         pi = a_index;
         pl = a_last;
      end else begin
         ph = 1'b0;
      end
   end

   task automatic push_bus(input logic wr, input int a, input logic [15:0] d);
      bus_t e;
      e.wr = wr;
      e.addr = 16'(a);
      e.data = d;
      bus_q.push_back(e);
   endtask

   task automatic push_frame(input frame_t r, input int polls, input bit tmo);
      out_t o;
      push_bus(1, 0, 16'd1);
      push_bus(1, 0, 16'd0);
      for (int i = 0; i < 11; i++) push_bus(1, 3 + i, r[i]);
      push_bus(1, 1, 16'd1);
      push_bus(1, 1, 16'd0);
      for (int i = 0; i < (tmo ? PT + 1 : polls + 1); i++)
         push_bus(0, 2, 16'd0);
      if (!tmo) begin
         for (int i = 0; i < 11; i++) begin
            push_bus(0, 14 + i, 16'd0);
            o.data = 16'(100 + 20 * fno + i);
            o.idx  = 4'(i);
            o.last = (i == 10);
            out_q.push_back(o);
         end
      end
      fno++;
   endtask

   task automatic send_word(input logic [15:0] d);
      int n;
      n = 0;
      r_data = d;
      r_valid = 1'b1;
      @(negedge clk);
      while (!r_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!r_ready) check("rready_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input frame_t r, input bit gaps);
      for (int i = 0; i < 11; i++) begin
         send_word(r[i]);
         if (gaps) begin
            r_valid = 1'b0;
            r_data = 16'hDEAD;
            @(posedge clk);
            #1;
         end
      end
      r_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 64'(busy), 64'd0);
      check("bus_left", 64'(bus_q.size()), 64'd0);
      check("out_left", 64'(out_q.size()), 64'd0);
   endtask

   function automatic frame_t rnd_frame();
      frame_t f;
      for (int i = 0; i < 11; i++) f[i] = 16'($urandom);
      return f;
   endfunction

   function automatic logic [63:0] outs();
      return {5'd0, busy, write, read, r_ready, a_valid, a_last, err,
              a_index, address, writedata, a_data};
   endfunction

   initial begin
      frame_t nom;
      frame_t f1;
      frame_t f2;
      int av0;
      nom = '{16'sd32767, 16'sd25742, 16'sd16169, 16'sd9836, 16'sd4569,
              -16'sd2674, -16'sd11249, -16'sd17338, -16'sd14853,
              -16'sd6828, -16'sd3174};

      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", outs(), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      done_after = 40;
      push_frame(nom, 40, 0);
      send_frame(nom, 0);
      wait_idle(2000);
      check("err_nominal", 64'(err), 64'd0);

      done_after = 3;
      f1 = rnd_frame();
      push_frame(f1, 3, 0);
      send_frame(f1, 1);
      wait_idle(2000);

      bp = 5;
      done_after = 2;
      f1 = rnd_frame();
      push_frame(f1, 2, 0);
      send_frame(f1, 0);
      wait_idle(4000);
      bp = 0;

      done_after = 1 << 30;
      av0 = av_cnt;
      f1 = rnd_frame();
      push_frame(f1, 0, 1);
      send_frame(f1, 0);
      wait_idle(20000);
      check("err_timeout", 64'(err), 64'd1);
      check("busy_timeout", 64'(busy), 64'd0);
      check("no_avalid", 64'(av_cnt - av0), 64'd0);

      done_after = 5;
      f1 = rnd_frame();
      push_frame(f1, 5, 0);
      send_frame(f1, 0);
      check("err_cleared", 64'(err), 64'd0);
      wait_idle(2000);

      f1 = rnd_frame();
      push_bus(1, 0, 16'd1);
      push_bus(1, 0, 16'd0);
      for (int i = 0; i < 5; i++) push_bus(1, 3 + i, f1[i]);
      for (int i = 0; i < 5; i++) send_word(f1[i]);
      rst = 1'b0;
      #1;
      check("midrst_outs", outs(), 64'd0);
      r_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("abort_log", 64'(bus_q.size()), 64'd0);
      rst = 1'b1;
      done_after = 1;
      f1 = rnd_frame();
      push_frame(f1, 1, 0);
      send_frame(f1, 0);
      wait_idle(2000);

      done_after = 4;
      f1 = rnd_frame();
      f2 = rnd_frame();
      push_frame(f1, 4, 0);
      push_frame(f2, 4, 0);
      send_frame(f1, 0);
      send_frame(f2, 0);
      wait_idle(4000);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/ldr_sequencer.md
Name: ldr_sequencer

Overview:
- Avalon-MM master that runs one Levinson-Durbin solve per frame on LDRavalonWrapper.
- Per frame it accepts 11 autocorrelation words R0..R10 on a valid/ready stream, resets the solver, loads R0..R10 and pulses start.
- It then polls the done register, reads back A0..A10 and emits them on an output stream.
- Sits between the autocorrelation stage and the coefficient consumer; it is the wrapper's only bus master.

Parameters:
- ORDER, 10, LPC order; frame is ORDER+1 words in and ORDER+1 words out.
- READ_LATENCY, 1, cycles from read pulse to valid readdata at the slave.
- POLL_TIMEOUT, 4095, maximum done-poll reads before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- r_data  in  16  signed autocorrelation word, R0 first
- r_valid  in  1  r_data valid
- r_ready  out  1  sequencer accepts r_data
- a_data  out  16  signed coefficient word, A0 first
- a_index  out  4  coefficient index 0..ORDER
- a_last  out  1  marks A[ORDER]
- a_valid  out  1  a_data valid
- a_ready  in  1  consumer accepts a_data
- address  out  16  Avalon address to wrapper
- read  out  1  single-cycle read strobe
- write  out  1  single-cycle write strobe
- writedata  out  16  Avalon write data
- readdata  in  16  Avalon read data, valid READ_LATENCY cycles after read
- busy  out  1  frame in progress (state != IDLE)
- err  out  1  sticky timeout flag; cleared when the next frame starts

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0, including address, writedata and a_data.
  - Index counter, poll counter and err cleared.
- The slave has no waitrequest; every read or write completes in its strobe cycle. At most one strobe is active per cycle.
- IDLE:
  - r_ready=0.
  - When r_valid=1, go to RST1. Do not consume the word. Clear err.
- RST1: write=1, address=0x0, writedata=1. Go to RST0.
- RST0: write=1, address=0x0, writedata=0. Clear k. Go to LOAD.
- LOAD:
  - r_ready=1.
  - On each r_valid&&r_ready cycle: write=1, address=0x3+k, writedata=r_data, k++.
  - Gaps in r_valid are allowed; write=0 in those cycles.
  - After k=ORDER is written, go to STA1.
- STA1: write address 0x1, data 1. Go to STA0.
- STA0: write address 0x1, data 0. Clear the poll counter. Go to POLL.
- POLL:
  - Issue read=1, address=0x2, then go to PWAIT.
- PWAIT:
  - Wait READ_LATENCY cycles, then sample readdata.
  - If readdata!=0: clear k, go to RD.
  - Else if poll counter==POLL_TIMEOUT: set err=1, go to IDLE. No coefficients are emitted.
  - Else: increment the poll counter, go to POLL.
  - The first poll read is issued the cycle after STA0.
- RD:
  - Issue read=1, address=0xE+k, then go to RWAIT.
- RWAIT:
  - After READ_LATENCY cycles, capture readdata into a_data.
  - Set a_index=k, a_last=(k==ORDER), a_valid=1. Go to OUT.
- OUT:
  - Hold a_data, a_index and a_last stable while a_valid=1 and a_ready=0.
  - On a_ready: a_valid=0.
  - If k==ORDER go to IDLE; else k++ and go to RD.
  - No new bus read is issued while a word is pending.
- Latency, no backpressure, READ_LATENCY=1:
  - From the last R accepted: 2 start-write cycles, then 2 cycles per poll.
  - Then 3 cycles per coefficient.
- Counter 0x19 is never accessed.
- r_valid asserted during non-LOAD states is ignored (r_ready=0).
- An asynchronous reset mid-frame aborts immediately. The next frame always begins with RST1, so the solver is re-initialised.
- a_index width is fixed at 4. ORDER is legal only in 1..15; synthesis-time check.

Decomposition:
- Package ldr_pkg holds the register map as constants:
  - LDR_ADDR_RST=0x0, LDR_ADDR_START=0x1, LDR_ADDR_DONE=0x2, LDR_ADDR_R0=0x3, LDR_ADDR_A0=0xE, LDR_ADDR_CNT=0x19.
  - The state enum.
- One sub-module, ldr_rd_align: a READ_LATENCY-deep shift register of the read strobe that produces rd_valid to the FSM.

Test Plan:
- Nominal frame:
  - Stimulus: stream R = 32767, 25742, 16169, 9836, 4569, -2674, -11249, -17338, -14853, -6828, -3174. Slave model asserts done after 40 polls and returns A_k = 100+k.
  - Required: bus log shows writes 0x0=1, 0x0=0, 0x3..0xD = R values in order, 0x1=1, 0x1=0.
  - Required: 41 reads of 0x2, then reads 0xE..0x18.
  - Required: output is 100..110, index 0..10, a_last only on index 10.
- Input gaps: r_valid toggles 1/0 during LOAD.
  - Required: exactly 11 writes with no duplicates, and write=0 in every gap cycle.
- Backpressure: a_ready low for 5 cycles on each word.
  - Required: a_data held stable, and no read strobe while a_valid=1.
- Timeout: done never asserted.
  - Required: exactly POLL_TIMEOUT+1 done reads, err=1, busy=0, no a_valid.
  - Required: the next frame clears err and completes normally.
- Mid-frame reset: drive rst=0 during LOAD after 5 words.
  - Required: all outputs 0 immediately.
  - Required: the next frame starts with 0x0=1 and loads all 11 words from R0.
- Back-to-back frames: second frame's r_valid held high during the first frame's OUT states.
  - Required: r_ready=0 until the second frame's LOAD, and both coefficient sets are output intact.
